// File: rtl/gcd_sched_pkg.sv
// Shared types and helpers for the round-robin GCD scheduler.
package gcd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    // Index width, never below one bit so single-bit ids stay legal.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gcd_sched_if.sv
// Request/response handshake bundle between requesters and the scheduler.
interface gcd_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 16
);
    import gcd_sched_pkg::*;

    localparam int IDW = id_width(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_gcd;
    logic              rsp_err;
    logic              rsp_ready;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_gcd, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_gcd, rsp_err
    );

endinterface

// File: rtl/gcd_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after i_ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);
    localparam int SW = IDW + 1;

    logic [SW-1:0]  w_sum;
    logic [IDW-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // One extra bit keeps ptr+k from overflowing before the wrap.
            w_sum = {1'b0, i_ptr} + SW'(k);
            if (w_sum >= SW'(NREQ))
                w_sum = w_sum - SW'(NREQ);
            w_pos = w_sum[IDW-1:0];
            if (!o_any && i_req[w_pos]) begin
                o_any          = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end
        end
    end

endmodule

// File: rtl/gcd_sched.sv
// Shares one subtractive GCD engine among NREQ requesters, one job at a time,
// with zero-operand bypass and a RUN-state watchdog.
module gcd_sched
    import gcd_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int MAX_CYC = 70000
) (
    input  logic         clk,
    input  logic         rst_n,
    gcd_sched_if.slave   bus,
    output logic         eng_start,
    output logic [W-1:0] eng_a,
    output logic [W-1:0] eng_b,
    input  logic         eng_done,
    input  logic [W-1:0] eng_result,
    output logic         eng_abort,
    output logic         busy
);
    localparam int IDW = id_width(NREQ);
    localparam int CW  = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_CYC - 1);
    localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

    state_t         r_state;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_gcd;
    logic           r_err;
    logic           r_start;
    logic [CW-1:0]  r_cnt;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_idx;
    logic            w_any;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;
    logic            w_timeout;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant[k]) begin
                w_sel_a = bus.req_a[k*W +: W];
                w_sel_b = bus.req_b[k*W +: W];
            end
        end
    end

    // A completion in the final budget cycle takes priority over the abort.
    assign w_timeout = (r_state == RUN) && !eng_done && (r_cnt == CNT_LAST);

    assign bus.req_ready = (rst_n && (r_state == IDLE)) ? w_grant : '0;
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_id    = r_id;
    assign bus.rsp_gcd   = r_gcd;
    assign bus.rsp_err   = r_err;
    assign eng_start     = r_start;
    assign eng_a         = r_a;
    assign eng_b         = r_b;
    assign eng_abort     = w_timeout;
    assign busy          = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_gcd   <= '0;
            r_err   <= 1'b0;
            r_start <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_id <= w_idx;
                        r_a  <= w_sel_a;
                        r_b  <= w_sel_b;
                        if ((w_sel_a == '0) || (w_sel_b == '0)) begin
                            r_gcd   <= w_sel_a | w_sel_b;
                            r_err   <= 1'b0;
                            r_state <= RESP;
                        end else begin
                            r_start <= 1'b1;
                            r_state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    r_start <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (eng_done) begin
                        r_gcd   <= eng_result;
                        r_err   <= 1'b0;
                        r_state <= RESP;
                    end else if (w_timeout) begin
                        r_gcd   <= '0;
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_ptr   <= (r_id == ID_LAST) ? '0 : r_id + 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_sched.sv
// Directed bench for gcd_sched with a behavioural engine of programmable latency.
module tb_gcd_sched;
    localparam int NREQ    = 4;
    localparam int W       = 16;
    localparam int MAX_CYC = 8;

    logic         clk;
    logic         rst_n;
    logic         eng_start, eng_done, eng_abort, busy;
    logic [W-1:0] eng_a, eng_b, eng_result;

    logic [W-1:0] tb_a [NREQ];
    logic [W-1:0] tb_b [NREQ];

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_abort  = 0;

    int   eng_lat   = 4;
    bit   eng_never = 1'b0;
    logic m_busy;
    int   m_cnt;
    logic [W-1:0] m_a, m_b;

    gcd_sched_if #(.NREQ(NREQ), .W(W)) bus ();

    gcd_sched #(.NREQ(NREQ), .W(W), .MAX_CYC(MAX_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .eng_start  (eng_start),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .eng_abort  (eng_abort),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            bus.req_a[k*W +: W] = tb_a[k];
            bus.req_b[k*W +: W] = tb_b[k];
        end
    end

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y;
        x = a;
        y = b;
        if (x == '0 || y == '0) return x | y;
        while (x != y) begin
            if (x > y) x = x - y;
            else       y = y - x;
        end
        return x;
    endfunction

    // Engine: done appears eng_lat+1 RUN cycles after the start pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy     <= 1'b0;
            m_cnt      <= 0;
            m_a        <= '0;
            m_b        <= '0;
            eng_done   <= 1'b0;
            eng_result <= '0;
        end else begin
            eng_done <= 1'b0;
            if (eng_start) begin
                m_busy <= 1'b1;
                m_cnt  <= eng_lat;
                m_a    <= eng_a;
                m_b    <= eng_b;
            end else if (eng_abort) begin
                m_busy <= 1'b0;
            end else if (m_busy && !eng_never) begin
                if (m_cnt <= 1) begin
                    eng_done   <= 1'b1;
                    eng_result <= gcd_ref(m_a, m_b);
                    m_busy     <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (eng_start === 1'b1) n_start <= n_start + 1;
        if (eng_abort === 1'b1) n_abort <= n_abort + 1;
    end

    task automatic set_req(input logic [1:0] i, input logic [W-1:0] a, input logic [W-1:0] b);
        tb_a[i] = a;
        tb_b[i] = b;
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_rsp(input int budget, output bit got, output bit prev_done, output int cyc);
        got = 1'b0;
        prev_done = 1'b0;
        cyc = 0;
        while (!bus.rsp_valid && cyc < budget) begin
            prev_done = eng_done;
            @(negedge clk);
            cyc++;
        end
        got = bus.rsp_valid;
    endtask

    task automatic pop_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            tb_a[k] = 16'd5;
            tb_b[k] = 16'd3;
        end
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); end
        n_checks++; if (bus.rsp_gcd !== 16'd0) begin n_fail++; $display("FAIL reset_rsp_gcd: got %0d expected 0", bus.rsp_gcd); end
        n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b expected 0", bus.rsp_err); end
        n_checks++; if (eng_start !== 1'b0 || eng_abort !== 1'b0) begin n_fail++; $display("FAIL reset_eng_pulses: start=%b abort=%b expected 0 0", eng_start, eng_abort); end
        n_checks++; if (eng_a !== 16'd0 || eng_b !== 16'd0) begin n_fail++; $display("FAIL reset_eng_ops: a=%0d b=%0d expected 0 0", eng_a, eng_b); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        bus.req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit got, pd;
        int cyc, s0;
        s0 = n_start;
        eng_lat = 4;
        set_req(2'd0, 16'd48, 16'd18);
        #1;
        n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b expected 0001", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid[0] = 1'b0;
        @(negedge clk);
        n_checks++; if (eng_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b expected 1", eng_start); end
        n_checks++; if (eng_a !== 16'd48 || eng_b !== 16'd18) begin n_fail++; $display("FAIL single_ops: a=%0d b=%0d expected 48 18", eng_a, eng_b); end
        n_checks++; if (busy !== 1'b1 || bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_busy: busy=%b req_ready=%b expected 1 0000", busy, bus.req_ready); end
        wait_rsp(30, got, pd, cyc);
        n_checks++; if (!got) begin n_fail++; $display("FAIL single_rsp_timeout: no rsp_valid after %0d cycles", cyc); end
        n_checks++; if (pd !== 1'b1) begin n_fail++; $display("FAIL single_rsp_latency: eng_done in previous cycle=%b expected 1", pd); end
        n_checks++; if (bus.rsp_id !== 2'd0 || bus.rsp_gcd !== 16'd6 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL single_rsp: id=%0d gcd=%0d err=%b expected 0 6 0", bus.rsp_id, bus.rsp_gcd, bus.rsp_err); end
        n_checks++; if (n_start - s0 != 1) begin n_fail++; $display("FAIL single_start_count: got %0d expected 1", n_start - s0); end
        pop_rsp();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy=%b expected 0", busy); end
    endtask

    task automatic test_contention();
        logic [1:0]   exp_id [5] = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2};
        logic [W-1:0] exp_g  [5] = '{16'd4, 16'd3, 16'd1, 16'd5, 16'd7};
        logic [3:0]   exp_rr [5] = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100};
        bit got, pd;
        int cyc;
        do_reset();
        eng_lat = 2;
        set_req(2'd0, 16'd12, 16'd8);
        set_req(2'd2, 16'd9, 16'd6);
        set_req(2'd3, 16'd7, 16'd5);
        for (int k = 0; k < 5; k++) begin
            if (k == 3) begin
                set_req(2'd2, 16'd14, 16'd21);
                set_req(2'd0, 16'd20, 16'd15);
            end
            #1;
            n_checks++; if (bus.req_ready !== exp_rr[k]) begin n_fail++; $display("FAIL contention_grant%0d: got %b expected %b", k, bus.req_ready, exp_rr[k]); end
            wait_rsp(30, got, pd, cyc);
            n_checks++; if (!got) begin n_fail++; $display("FAIL contention_timeout%0d: no rsp after %0d cycles", k, cyc); end
            n_checks++; if (bus.rsp_id !== exp_id[k] || bus.rsp_gcd !== exp_g[k]) begin n_fail++; $display("FAIL contention_rsp%0d: id=%0d gcd=%0d expected %0d %0d", k, bus.rsp_id, bus.rsp_gcd, exp_id[k], exp_g[k]); end
            bus.req_valid[exp_id[k]] = 1'b0;
            pop_rsp();
        end
    endtask

    task automatic test_zero();
        logic [W-1:0] za [3] = '{16'd0, 16'd0, 16'd21};
        logic [W-1:0] zb [3] = '{16'd35, 16'd0, 16'd0};
        logic [W-1:0] zg [3] = '{16'd35, 16'd0, 16'd21};
        int s0;
        s0 = n_start;
        for (int k = 0; k < 3; k++) begin
            set_req(2'd1, za[k], zb[k]);
            #1;
            n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL zero_grant%0d: got %b expected 0010", k, bus.req_ready); end
            @(posedge clk);
            #1 bus.req_valid[1] = 1'b0;
            @(negedge clk);
            n_checks++; if (bus.rsp_valid !== 1'b1 || eng_start !== 1'b0) begin n_fail++; $display("FAIL zero_timing%0d: rsp_valid=%b eng_start=%b expected 1 0", k, bus.rsp_valid, eng_start); end
            n_checks++; if (bus.rsp_id !== 2'd1 || bus.rsp_gcd !== zg[k] || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL zero_rsp%0d: id=%0d gcd=%0d err=%b expected 1 %0d 0", k, bus.rsp_id, bus.rsp_gcd, bus.rsp_err, zg[k]); end
            pop_rsp();
        end
        n_checks++; if (n_start != s0) begin n_fail++; $display("FAIL zero_no_start: %0d start pulses expected 0", n_start - s0); end
    endtask

    task automatic test_watchdog();
        bit           wnever [2] = '{1'b1, 1'b0};
        int           wlat   [2] = '{0, 7};
        logic [W-1:0] wa     [2] = '{16'd10, 16'd27};
        logic [W-1:0] wb     [2] = '{16'd4, 16'd18};
        logic [W-1:0] wg     [2] = '{16'd0, 16'd9};
        logic         werr   [2] = '{1'b1, 1'b0};
        int           wab    [2] = '{8, 0};
        int n, ab, a0;
        for (int v = 0; v < 2; v++) begin
            eng_never = wnever[v];
            eng_lat   = wlat[v];
            a0 = n_abort;
            set_req(2'd3, wa[v], wb[v]);
            #1;
            n_checks++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL wd_grant%0d: got %b expected 1000", v, bus.req_ready); end
            @(posedge clk);
            #1 bus.req_valid[3] = 1'b0;
            @(negedge clk);
            n = 0;
            ab = 0;
            while (!bus.rsp_valid && n < 30) begin
                @(negedge clk);
                n++;
                if (eng_abort === 1'b1 && ab == 0) ab = n;
            end
            n_checks++; if (ab != wab[v]) begin n_fail++; $display("FAIL wd_abort_cycle%0d: abort in RUN cycle %0d expected %0d", v, ab, wab[v]); end
            n_checks++; if (n != 9) begin n_fail++; $display("FAIL wd_rsp_cycle%0d: rsp_valid after %0d cycles expected 9", v, n); end
            n_checks++; if (bus.rsp_id !== 2'd3 || bus.rsp_gcd !== wg[v] || bus.rsp_err !== werr[v]) begin n_fail++; $display("FAIL wd_rsp%0d: id=%0d gcd=%0d err=%b expected 3 %0d %b", v, bus.rsp_id, bus.rsp_gcd, bus.rsp_err, wg[v], werr[v]); end
            pop_rsp();
            n_checks++; if (n_abort - a0 != int'(werr[v])) begin n_fail++; $display("FAIL wd_abort_count%0d: got %0d expected %0d", v, n_abort - a0, werr[v]); end
        end
        eng_never = 1'b0;
    endtask

    task automatic test_backpressure();
        bit got, pd;
        int cyc;
        do_reset();
        eng_lat = 2;
        set_req(2'd0, 16'd48, 16'd18);
        set_req(2'd1, 16'd15, 16'd10);
        wait_rsp(30, got, pd, cyc);
        n_checks++; if (!got || bus.rsp_id !== 2'd0 || bus.rsp_gcd !== 16'd6) begin n_fail++; $display("FAIL bp_first: got=%b id=%0d gcd=%0d expected 1 0 6", got, bus.rsp_id, bus.rsp_gcd); end
        bus.req_valid[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_gcd !== 16'd6 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL bp_hold%0d: valid=%b id=%0d gcd=%0d err=%b expected 1 0 6 0", k, bus.rsp_valid, bus.rsp_id, bus.rsp_gcd, bus.rsp_err); end
            n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready%0d: got %b expected 0000", k, bus.req_ready); end
        end
        pop_rsp();
        n_checks++; if (bus.req_ready !== 4'b0010 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_regrant: req_ready=%b busy=%b expected 0010 0", bus.req_ready, busy); end
        wait_rsp(30, got, pd, cyc);
        n_checks++; if (!got || bus.rsp_id !== 2'd1 || bus.rsp_gcd !== 16'd5) begin n_fail++; $display("FAIL bp_second: got=%b id=%0d gcd=%0d expected 1 1 5", got, bus.rsp_id, bus.rsp_gcd); end
        bus.req_valid[1] = 1'b0;
        pop_rsp();
    endtask

    task automatic test_reset_run();
        bit got, pd;
        int cyc, a0;
        a0 = n_abort;
        eng_lat = 4;
        set_req(2'd2, 16'd48, 16'd18);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_ctrl: busy=%b rsp_valid=%b req_ready=%b expected 0 0 0000", busy, bus.rsp_valid, bus.req_ready); end
        n_checks++; if (eng_start !== 1'b0 || eng_abort !== 1'b0 || eng_a !== 16'd0 || eng_b !== 16'd0) begin n_fail++; $display("FAIL rr_eng: start=%b abort=%b a=%0d b=%0d expected 0 0 0 0", eng_start, eng_abort, eng_a, eng_b); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL rr_regrant: got %b expected 0100", bus.req_ready); end
        wait_rsp(30, got, pd, cyc);
        n_checks++; if (!got || bus.rsp_id !== 2'd2 || bus.rsp_gcd !== 16'd6 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rr_rsp: got=%b id=%0d gcd=%0d err=%b expected 1 2 6 0", got, bus.rsp_id, bus.rsp_gcd, bus.rsp_err); end
        bus.req_valid[2] = 1'b0;
        pop_rsp();
        n_checks++; if (n_abort != a0) begin n_fail++; $display("FAIL rr_no_abort: %0d abort pulses expected 0", n_abort - a0); end
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            tb_a[k] = '0;
            tb_b[k] = '0;
        end
        test_reset();
        test_single();
        test_contention();
        test_zero();
        test_watchdog();
        test_backpressure();
        test_reset_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
